// File: rtl/ring_osc_freq_counter_if.sv
// Result/handshake bundle between the ring-oscillator frequency counter and the PVT monitor controller.
// The controller side is the master (issues start, accepts results); the counter is the slave.
interface ring_osc_freq_counter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             busy;
    logic             valid;
    logic             ready;
    logic             overflow;
    logic [CNT_W-1:0] count;

    modport master (
        output start, ready,
        input  busy, valid, overflow, count
    );

    modport slave (
        input  start, ready,
        output busy, valid, overflow, count
    );
endinterface

// File: rtl/ring_osc_freq_counter.sv
// Ring-oscillator frequency counter: enables the ring, settles, then counts synchronised
// osc_in rising edges over a fixed clk gate window and hands the count over valid/ready.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ring off, last result held, waiting for start
// SETTLE  | ring enabled, waiting SETTLE_CYCLES before counting
// MEASURE | ring enabled, counting edges for GATE_CYCLES cycles
// DONE    | ring off, result valid until the consumer takes it
module ring_osc_freq_counter #(
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          osc_in,
    output logic                          osc_ena,
    ring_osc_freq_counter_if.slave        bus
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               overflow, overflow_nxt;
    logic               osc_ena_nxt;
    logic               s1, s2, s3;
    logic               osc_edge;

    assign osc_edge = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            osc_ena  <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
            osc_ena  <= osc_ena_nxt;
            s1       <= osc_in;
            s2       <= s1;
            s3       <= s2;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        count_nxt    = count;
        overflow_nxt = overflow;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt    = SETTLE;
                    timer_nxt    = TMR_W'(SETTLE_CYCLES - 1);
                    count_nxt    = '0;
                    overflow_nxt = 1'b0;
                end
            end
            SETTLE: begin
                if (timer == '0) begin
                    state_nxt = MEASURE;
                    timer_nxt = TMR_W'(GATE_CYCLES - 1);
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            MEASURE: begin
                // counter sticks at all-ones; further edges only flag overflow
                if (osc_edge) begin
                    if (count == {CNT_W{1'b1}}) overflow_nxt = 1'b1;
                    else                        count_nxt    = count + CNT_W'(1);
                end
                if (timer == '0) state_nxt = DONE;
                else             timer_nxt = timer - TMR_W'(1);
            end
            DONE: begin
                if (bus.ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        osc_ena_nxt = (state_nxt == SETTLE) || (state_nxt == MEASURE);
    end

    assign bus.busy     = (state != IDLE);
    assign bus.valid    = (state == DONE);
    assign bus.count    = count;
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Directed bench for ring_osc_freq_counter: a 16-bit and a 6-bit instance, each with its own
// oscillator generator, checked against hand-computed latency, count and overflow values.
module tb_ring_osc_freq_counter;

    logic clk = 1'b0;
    logic rst_n;
    logic osc_a = 1'b0;
    logic osc_b = 1'b0;
    logic ena_a, ena_b;
    int   half_a = 40;
    int   half_b = 20;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always begin
        if (half_a == 0) begin
            osc_a = 1'b0;
            #10;
        end else begin
            #(half_a) osc_a = ~osc_a;
        end
    end

    always begin
        if (half_b == 0) begin
            osc_b = 1'b0;
            #10;
        end else begin
            #(half_b) osc_b = ~osc_b;
        end
    end

    ring_osc_freq_counter_if #(.CNT_W(16)) if_a ();
    ring_osc_freq_counter_if #(.CNT_W(6))  if_b ();

    ring_osc_freq_counter #(.GATE_CYCLES(1024), .SETTLE_CYCLES(16), .CNT_W(16)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .osc_in  (osc_a),
        .osc_ena (ena_a),
        .bus     (if_a.slave)
    );

    ring_osc_freq_counter #(.GATE_CYCLES(1024), .SETTLE_CYCLES(16), .CNT_W(6)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .osc_in  (osc_b),
        .osc_ena (ena_b),
        .bus     (if_b.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_valid(input bit sel);
        return sel ? if_b.valid : if_a.valid;
    endfunction

    function automatic logic get_ena(input bit sel);
        return sel ? ena_b : ena_a;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) if_b.start = v;
        else     if_a.start = v;
    endtask

    task automatic set_ready(input bit sel, input logic v);
        if (sel) if_b.ready = v;
        else     if_a.ready = v;
    endtask

    // Start at a negedge; returns negedges elapsed until valid and negedges with osc_ena high.
    task automatic run_meas(input bit sel, input int pulse_at, output int cyc, output int ena_cyc);
        cyc = 0;
        ena_cyc = 0;
        set_start(sel, 1'b1);
        while (!get_valid(sel) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) set_start(sel, 1'b0);
            if (pulse_at != 0 && cyc == pulse_at)     set_start(sel, 1'b1);
            if (pulse_at != 0 && cyc == pulse_at + 1) set_start(sel, 1'b0);
            if (get_ena(sel)) ena_cyc++;
        end
    endtask

    task automatic ack(input bit sel, input string tag);
        set_ready(sel, 1'b1);
        @(negedge clk);
        set_ready(sel, 1'b0);
        check_val({tag, "_valid_clr"}, 32'(get_valid(sel)), 32'd0);
        check_val({tag, "_busy_clr"}, 32'(sel ? if_b.busy : if_a.busy), 32'd0);
    endtask

    initial begin
        int cyc, ena_cyc, unstable, busy_seen;
        logic [15:0] held;

        rst_n = 1'b0;
        if_a.start = 1'b0; if_a.ready = 1'b0;
        if_b.start = 1'b0; if_b.ready = 1'b0;
        #12;
        check_val("rst_ena",   32'(ena_a), 32'd0);
        check_val("rst_busy",  32'(if_a.busy), 32'd0);
        check_val("rst_valid", 32'(if_a.valid), 32'd0);
        check_val("rst_count", 32'(if_a.count), 32'd0);
        check_val("rst_ovf",   32'(if_a.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: osc period 8 clk -> 1024/8 edges
        run_meas(1'b0, 0, cyc, ena_cyc);
        check_val("t1_latency", 32'(cyc), 32'd1041);
        check_val("t1_ena_cyc", 32'(ena_cyc), 32'd1040);
        check_val("t1_count", 32'(if_a.count), 32'd128);
        check_val("t1_ovf", 32'(if_a.overflow), 32'd0);
        ack(1'b0, "t1");

        // 2: osc held low, ready held high throughout (no effect until valid)
        half_a = 0;
        repeat (5) @(negedge clk);
        if_a.ready = 1'b1;
        run_meas(1'b0, 0, cyc, ena_cyc);
        check_val("t2_latency", 32'(cyc), 32'd1041);
        check_val("t2_ena_cyc", 32'(ena_cyc), 32'd1040);
        check_val("t2_count", 32'(if_a.count), 32'd0);
        ack(1'b0, "t2");

        // 3: 6-bit counter, period 4 clk -> 256 edges saturate at 63
        run_meas(1'b1, 0, cyc, ena_cyc);
        check_val("t3_latency", 32'(cyc), 32'd1041);
        check_val("t3_count_sat", 32'(if_b.count), 32'd63);
        check_val("t3_ovf_set", 32'(if_b.overflow), 32'd1);
        ack(1'b1, "t3a");
        check_val("t3_ovf_held", 32'(if_b.overflow), 32'd1);
        half_b = 0;
        repeat (5) @(negedge clk);
        run_meas(1'b1, 0, cyc, ena_cyc);
        check_val("t3_count_zero", 32'(if_b.count), 32'd0);
        check_val("t3_ovf_clr", 32'(if_b.overflow), 32'd0);
        ack(1'b1, "t3b");

        // 4+5: start pulse mid-MEASURE, ready low 50 cycles, then ready with start in DONE
        half_a = 40;
        repeat (5) @(negedge clk);
        run_meas(1'b0, 500, cyc, ena_cyc);
        check_val("t5_latency", 32'(cyc), 32'd1041);
        check_val("t5_count", 32'(if_a.count), 32'd128);
        held = if_a.count;
        unstable = 0;
        repeat (50) begin
            @(negedge clk);
            if (!if_a.valid || if_a.count !== held) unstable++;
        end
        check_val("t4_stable", 32'(unstable), 32'd0);
        check_val("t4_count_held", 32'(if_a.count), 32'd128);
        if_a.ready = 1'b1;
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.ready = 1'b0;
        if_a.start = 1'b0;
        check_val("t4_valid_clr", 32'(if_a.valid), 32'd0);
        check_val("t4_busy_clr", 32'(if_a.busy), 32'd0);
        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (if_a.busy || ena_a) busy_seen++;
        end
        check_val("t5_no_restart", 32'(busy_seen), 32'd0);

        // 6: reset mid-MEASURE aborts immediately, then a normal run
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        repeat (600) @(negedge clk);
        check_val("t6_ena_before", 32'(ena_a), 32'd1);
        check_val("t6_cnt_nz", 32'(if_a.count != 16'd0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_ena", 32'(ena_a), 32'd0);
        check_val("t6_busy", 32'(if_a.busy), 32'd0);
        check_val("t6_valid", 32'(if_a.valid), 32'd0);
        check_val("t6_count", 32'(if_a.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_meas(1'b0, 0, cyc, ena_cyc);
        check_val("t6_latency", 32'(cyc), 32'd1041);
        check_val("t6_count_rerun", 32'(if_a.count), 32'd128);
        ack(1'b0, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
